// File: rtl/zeroriscy_arb_sram.sv
// Two-master shared data SRAM for the zero-riscy FPGA build.
//   m0 = instruction fetch, m1 = LSU, both on the core's req/gnt/rvalid bus.
//   One byte-enabled RAM, one access per cycle. Round-robin arbitration,
//   configurable read latency, and an address-range check that reports a bus error.
//
// Parameters:
//   MEM_BYTES  RAM size in bytes (power of two, >= 4)
//   BASE_ADDR  byte address of word 0 (aligned to MEM_BYTES)
//   LATENCY    cycles from grant to rvalid (>= 1)
//
// Ports (N in {0,1}):
//   clk, rst_n            clock (posedge), async active-low reset
//   mN_req/we/be/addr/wdata  request and its fields, valid while req=1
//   mN_gnt                combinational grant in the cycle the request is accepted
//   mN_rvalid             one-cycle response strobe, exactly one per grant
//   mN_rdata              read data; 0 when no response, for writes and on error
//   mN_err                qualified by rvalid: access was out of range
module zeroriscy_arb_sram #(
  parameter int unsigned MEM_BYTES = 32'h20000,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("zeroriscy_arb_sram: LATENCY must be >= 1");
  end

  localparam int unsigned L     = (LATENCY < 1) ? 1 : LATENCY;
  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  // rr_last: id of the most recently granted master (1 after reset, so m0 wins first tie)
  logic          rr_last;
  logic          gnt0, gnt1, any_gnt;

  logic          sel_we;
  logic [3:0]    sel_be;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [31:0]   off;
  logic          in_range;
  logic [IW-1:0] idx;
  logic          wr_en, rd_en;

  logic [31:0]   mem [WORDS];

  // Response pipeline; stage L-1 drives the outputs
  logic [L-1:0]  v_q, id_q, we_q, err_q;
  logic [31:0]   dat_q [L];

  always_comb begin
    gnt0    = m0_req & (~m1_req | rr_last);
    gnt1    = m1_req & (~m0_req | ~rr_last);
    any_gnt = gnt0 | gnt1;

    sel_we    = gnt1 ? m1_we    : m0_we;
    sel_be    = gnt1 ? m1_be    : m0_be;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;

    off      = sel_addr - BASE_ADDR;
    in_range = (sel_addr >= BASE_ADDR) && (off < MEM_BYTES);
    idx      = IW'(off >> 2);

    wr_en = any_gnt & sel_we  & in_range;
    rd_en = any_gnt & ~sel_we & in_range;
  end

  always_comb begin
    m0_gnt = gnt0;
    m1_gnt = gnt1;
  end

  // RAM and read-data pipeline carry no reset: contents survive reset, and the
  // data stages are only observed through the (reset) valid bits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_be[b]) mem[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
    dat_q[0] <= rd_en ? mem[idx] : '0;
    for (int unsigned i = 1; i < L; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
      v_q     <= '0;
      id_q    <= '0;
      we_q    <= '0;
      err_q   <= '0;
    end else begin
      if (any_gnt) rr_last <= gnt1;
      v_q[0]   <= any_gnt;
      id_q[0]  <= gnt1;
      we_q[0]  <= sel_we;
      err_q[0] <= any_gnt & ~in_range;
      for (int unsigned i = 1; i < L; i++) begin
        v_q[i]   <= v_q[i-1];
        id_q[i]  <= id_q[i-1];
        we_q[i]  <= we_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  always_comb begin
    m0_rvalid = v_q[L-1] & ~id_q[L-1];
    m1_rvalid = v_q[L-1] &  id_q[L-1];
    m0_err    = m0_rvalid & err_q[L-1];
    m1_err    = m1_rvalid & err_q[L-1];
    m0_rdata  = (m0_rvalid & ~we_q[L-1] & ~err_q[L-1]) ? dat_q[L-1] : '0;
    m1_rdata  = (m1_rvalid & ~we_q[L-1] & ~err_q[L-1]) ? dat_q[L-1] : '0;
  end

endmodule
